// File: rtl/active_list.sv
// In-order retirement buffer: allocate at tail, mark complete by index, retire from head; flush walks back youngest-first undoing renames.
// Latency: alloc_index combinational; commit/free/rollback outputs registered one cycle after the edge that retires or steps an entry.
// Backpressure: alloc_ready drops when full, during flush and throughout rollback; optional counters under ACTIVE_LIST_STATS_EN.
module active_list #(
    parameter int FREE_LIST_WIDTH = 3,
    parameter int VREG_ADDR_WIDTH = 5,
    parameter int PREG_ADDR_WIDTH = 6,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    output logic [FREE_LIST_WIDTH-1:0] alloc_index,
    input  logic                       alloc_wb_reg,
    input  logic [VREG_ADDR_WIDTH-1:0] alloc_vreg,
    input  logic [PREG_ADDR_WIDTH-1:0] alloc_preg,
    input  logic [PREG_ADDR_WIDTH-1:0] alloc_old_preg,
    input  logic [ADDR_WIDTH-1:0]      alloc_pc,
    input  logic                       complete_valid,
    input  logic [FREE_LIST_WIDTH-1:0] complete_index,
    output logic                       commit_valid,
    output logic [ADDR_WIDTH-1:0]      commit_pc,
    output logic                       free_valid,
    output logic [PREG_ADDR_WIDTH-1:0] free_preg,
    output logic                       rollback_valid,
    output logic [VREG_ADDR_WIDTH-1:0] rollback_vreg,
    output logic [PREG_ADDR_WIDTH-1:0] rollback_old_preg,
    output logic [PREG_ADDR_WIDTH-1:0] rollback_free_preg,
    output logic                       busy,
`ifdef ACTIVE_LIST_STATS_EN
    output logic [31:0]                perf_commit_count,
    output logic [31:0]                perf_squash_count,
`endif
    output logic                       empty
);

    localparam int DEPTH = 1 << FREE_LIST_WIDTH;
    localparam logic [FREE_LIST_WIDTH:0] FULL = {1'b1, {FREE_LIST_WIDTH{1'b0}}};

    typedef enum logic {RUN, ROLLBACK} state_t;

    state_t                      state, state_nxt;
    logic [FREE_LIST_WIDTH-1:0]  head, tail, tail_m1;
    logic [FREE_LIST_WIDTH:0]    count;

    logic [DEPTH-1:0]            ent_valid, ent_done, ent_wb;
    logic [VREG_ADDR_WIDTH-1:0]  ent_vreg     [DEPTH];
    logic [PREG_ADDR_WIDTH-1:0]  ent_preg     [DEPTH];
    logic [PREG_ADDR_WIDTH-1:0]  ent_old_preg [DEPTH];
    logic [ADDR_WIDTH-1:0]       ent_pc       [DEPTH];

    logic alloc_fire, commit_fire, comp_fire, step;

    assign tail_m1     = tail - 1'b1;
    assign step        = (state == ROLLBACK);
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign commit_fire = (state == RUN) && !flush && ent_valid[head] && ent_done[head];
    assign comp_fire   = (state == RUN) && !flush && complete_valid && ent_valid[complete_index];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      if (flush && (count != '0)) state_nxt = ROLLBACK;
            ROLLBACK: if (count == {{FREE_LIST_WIDTH{1'b0}}, 1'b1}) state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
    end

    always_comb begin
        alloc_ready = (state == RUN) && (count != FULL) && !flush;
        busy        = (state == ROLLBACK);
        empty       = (count == '0);
        alloc_index = tail;
    end

    // A rollback step owns the pointers exclusively; nothing else moves in ROLLBACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
            ent_done  <= '0;
        end else if (step) begin
            tail               <= tail_m1;
            count              <= count - 1'b1;
            ent_valid[tail_m1] <= 1'b0;
        end else begin
            if (alloc_fire) begin
                tail            <= tail + 1'b1;
                ent_valid[tail] <= 1'b1;
                ent_done[tail]  <= 1'b0;
            end
            if (commit_fire) begin
                head            <= head + 1'b1;
                ent_valid[head] <= 1'b0;
            end
            if (comp_fire) ent_done[complete_index] <= 1'b1;
            count <= count + (FREE_LIST_WIDTH+1)'(alloc_fire) - (FREE_LIST_WIDTH+1)'(commit_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            ent_wb[tail]       <= alloc_wb_reg;
            ent_vreg[tail]     <= alloc_vreg;
            ent_preg[tail]     <= alloc_preg;
            ent_old_preg[tail] <= alloc_old_preg;
            ent_pc[tail]       <= alloc_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_valid       <= 1'b0;
            commit_pc          <= '0;
            free_valid         <= 1'b0;
            free_preg          <= '0;
            rollback_valid     <= 1'b0;
            rollback_vreg      <= '0;
            rollback_old_preg  <= '0;
            rollback_free_preg <= '0;
        end else begin
            commit_valid       <= commit_fire;
            commit_pc          <= commit_fire ? ent_pc[head] : '0;
            free_valid         <= commit_fire && ent_wb[head];
            free_preg          <= commit_fire ? ent_old_preg[head] : '0;
            rollback_valid     <= step && ent_wb[tail_m1];
            rollback_vreg      <= step ? ent_vreg[tail_m1] : '0;
            rollback_old_preg  <= step ? ent_old_preg[tail_m1] : '0;
            rollback_free_preg <= step ? ent_preg[tail_m1] : '0;
        end
    end

`ifdef ACTIVE_LIST_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_commit_count <= '0;
            perf_squash_count <= '0;
        end else begin
            if (commit_fire) perf_commit_count <= perf_commit_count + 32'd1;
            if (step)        perf_squash_count <= perf_squash_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_active_list.sv
// Bench for active_list: directed table, fill/wrap/full-commit sequences, then random traffic against a queue model.
module tb_active_list;

    logic        clk = 1'b0;
    logic        rst_n, flush, alloc_valid, alloc_wb_reg, complete_valid;
    logic [4:0]  alloc_vreg;
    logic [5:0]  alloc_preg, alloc_old_preg;
    logic [31:0] alloc_pc;
    logic [2:0]  complete_index;
    logic        alloc_ready, commit_valid, free_valid, rollback_valid, busy, empty;
    logic [2:0]  alloc_index;
    logic [31:0] commit_pc;
    logic [5:0]  free_preg, rollback_old_preg, rollback_free_preg;
    logic [4:0]  rollback_vreg;

    active_list dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_index(alloc_index),
        .alloc_wb_reg(alloc_wb_reg), .alloc_vreg(alloc_vreg), .alloc_preg(alloc_preg),
        .alloc_old_preg(alloc_old_preg), .alloc_pc(alloc_pc),
        .complete_valid(complete_valid), .complete_index(complete_index),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .free_valid(free_valid), .free_preg(free_preg),
        .rollback_valid(rollback_valid), .rollback_vreg(rollback_vreg),
        .rollback_old_preg(rollback_old_preg), .rollback_free_preg(rollback_free_preg),
        .busy(busy), .empty(empty)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_in();
        flush = 1'b0; alloc_valid = 1'b0; alloc_wb_reg = 1'b0; alloc_vreg = '0;
        alloc_preg = '0; alloc_old_preg = '0; alloc_pc = '0;
        complete_valid = 1'b0; complete_index = '0;
    endtask

    task automatic drive_alloc(input int wb, input int vreg, input int preg, input int old, input logic [31:0] pc);
        alloc_valid = 1'b1; alloc_wb_reg = 1'(wb); alloc_vreg = 5'(vreg);
        alloc_preg = 6'(preg); alloc_old_preg = 6'(old); alloc_pc = pc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_in();
        rst_n = 1'b0;
        #1;
        chk("rst_empty", 32'(empty), 1);
        chk("rst_ready", 32'(alloc_ready), 1);
        chk("rst_index", 32'(alloc_index), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_commit", 32'(commit_valid), 0);
        chk("rst_rollback", 32'(rollback_valid), 0);
        chk("rst_free", 32'(free_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int av, wb, vreg, preg, old; logic [31:0] pc; int cin, cidx, fl;
        int e_ready, e_idx, e_empty, e_busy, e_cv; logic [31:0] e_pc; int e_fv, e_fp;
        int e_rb, e_rvreg, e_rold, e_rfree;
    } vec_t;

    vec_t tbl [18];

    typedef struct { int idx, wb, vreg, preg, old; logic [31:0] pc; bit done; } ment_t;
    ment_t q [$];
    int  m_tail;
    bit  m_busy;
    int  x_cv, x_fv, x_fp, x_rb, x_rv, x_ro, x_rf;
    logic [31:0] x_cpc;

    task automatic model_edge();
        ment_t e;
        bit can_alloc;
        x_cv = 0; x_cpc = '0; x_fv = 0; x_fp = 0; x_rb = 0; x_rv = 0; x_ro = 0; x_rf = 0;
        if (m_busy) begin
            e = q.pop_back();
            x_rb = e.wb; x_rv = e.vreg; x_ro = e.old; x_rf = e.preg;
            m_tail = (m_tail + 7) % 8;
            if (q.size() == 0) m_busy = 0;
        end else if (flush) begin
            if (q.size() != 0) m_busy = 1;
        end else begin
            can_alloc = alloc_valid && (q.size() < 8);
            if (q.size() > 0 && q[0].done) begin
                e = q.pop_front();
                x_cv = 1; x_cpc = e.pc; x_fv = e.wb; x_fp = e.old;
            end
            if (complete_valid)
                for (int k = 0; k < q.size(); k++)
                    if (q[k].idx == int'(complete_index)) q[k].done = 1;
            if (can_alloc) begin
                e = '{idx: m_tail, wb: int'(alloc_wb_reg), vreg: int'(alloc_vreg), preg: int'(alloc_preg),
                      old: int'(alloc_old_preg), pc: alloc_pc, done: 0};
                q.push_back(e);
                m_tail = (m_tail + 1) % 8;
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        idle_in();
        //          av wb vr pr old pc   cin ci fl | rdy idx emp bsy cv pc  fv fp rb rv ro rf
        tbl[0]  = '{1, 1, 1, 10, 20, 100, 0, 0, 0,  1, 0, 1, 0, 0, 0,   0, 0,  0, 0, 0,  0};
        tbl[1]  = '{1, 0, 2, 11, 21, 104, 0, 0, 0,  1, 1, 0, 0, 0, 0,   0, 0,  0, 0, 0,  0};
        tbl[2]  = '{1, 1, 3, 12, 22, 108, 0, 0, 0,  1, 2, 0, 0, 0, 0,   0, 0,  0, 0, 0,  0};
        tbl[3]  = '{0, 0, 0, 0,  0,  0,   1, 2, 0,  1, 3, 0, 0, 0, 0,   0, 0,  0, 0, 0,  0};
        tbl[4]  = '{0, 0, 0, 0,  0,  0,   1, 1, 0,  1, 3, 0, 0, 0, 0,   0, 0,  0, 0, 0,  0};
        tbl[5]  = '{0, 0, 0, 0,  0,  0,   1, 0, 0,  1, 3, 0, 0, 0, 0,   0, 0,  0, 0, 0,  0};
        tbl[6]  = '{0, 0, 0, 0,  0,  0,   0, 0, 0,  1, 3, 0, 0, 0, 0,   0, 0,  0, 0, 0,  0};
        tbl[7]  = '{0, 0, 0, 0,  0,  0,   0, 0, 0,  1, 3, 0, 0, 1, 100, 1, 20, 0, 0, 0,  0};
        tbl[8]  = '{0, 0, 0, 0,  0,  0,   0, 0, 0,  1, 3, 0, 0, 1, 104, 0, 21, 0, 0, 0,  0};
        tbl[9]  = '{1, 1, 3, 30, 40, 200, 0, 0, 0,  1, 3, 1, 0, 1, 108, 1, 22, 0, 0, 0,  0};
        tbl[10] = '{1, 0, 4, 31, 41, 204, 0, 0, 0,  1, 4, 0, 0, 0, 0,   0, 0,  0, 0, 0,  0};
        tbl[11] = '{1, 1, 5, 32, 42, 208, 0, 0, 0,  1, 5, 0, 0, 0, 0,   0, 0,  0, 0, 0,  0};
        tbl[12] = '{1, 1, 6, 33, 43, 300, 0, 0, 1,  0, 6, 0, 0, 0, 0,   0, 0,  0, 0, 0,  0};
        tbl[13] = '{0, 0, 0, 0,  0,  0,   0, 0, 0,  0, 6, 0, 1, 0, 0,   0, 0,  0, 0, 0,  0};
        tbl[14] = '{0, 0, 0, 0,  0,  0,   0, 0, 0,  0, 5, 0, 1, 0, 0,   0, 0,  1, 5, 42, 32};
        tbl[15] = '{0, 0, 0, 0,  0,  0,   0, 0, 0,  0, 4, 0, 1, 0, 0,   0, 0,  0, 4, 41, 31};
        tbl[16] = '{0, 0, 0, 0,  0,  0,   0, 0, 0,  1, 3, 1, 0, 0, 0,   0, 0,  1, 3, 40, 30};
        tbl[17] = '{0, 0, 0, 0,  0,  0,   0, 0, 0,  1, 3, 1, 0, 0, 0,   0, 0,  0, 0, 0,  0};

        do_reset();
        for (int r = 0; r < 18; r++) begin
            @(negedge clk);
            idle_in();
            if (tbl[r].av != 0) drive_alloc(tbl[r].wb, tbl[r].vreg, tbl[r].preg, tbl[r].old, tbl[r].pc);
            complete_valid = 1'(tbl[r].cin);
            complete_index = 3'(tbl[r].cidx);
            flush          = 1'(tbl[r].fl);
            #1;
            chk($sformatf("t%0d_ready", r), 32'(alloc_ready), tbl[r].e_ready);
            chk($sformatf("t%0d_index", r), 32'(alloc_index), tbl[r].e_idx);
            chk($sformatf("t%0d_empty", r), 32'(empty), tbl[r].e_empty);
            chk($sformatf("t%0d_busy", r), 32'(busy), tbl[r].e_busy);
            chk($sformatf("t%0d_cv", r), 32'(commit_valid), tbl[r].e_cv);
            chk($sformatf("t%0d_cpc", r), commit_pc, tbl[r].e_pc);
            chk($sformatf("t%0d_fv", r), 32'(free_valid), tbl[r].e_fv);
            chk($sformatf("t%0d_fp", r), 32'(free_preg), tbl[r].e_fp);
            chk($sformatf("t%0d_rb", r), 32'(rollback_valid), tbl[r].e_rb);
            chk($sformatf("t%0d_rvreg", r), 32'(rollback_vreg), tbl[r].e_rvreg);
            chk($sformatf("t%0d_rold", r), 32'(rollback_old_preg), tbl[r].e_rold);
            chk($sformatf("t%0d_rfree", r), 32'(rollback_free_preg), tbl[r].e_rfree);
        end

        // Fill to capacity, reject a ninth, then full + head done + alloc.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            idle_in();
            drive_alloc(1, i, i + 8, i + 16, 32'(500 + 4 * i));
            #1;
            chk($sformatf("fill%0d_ready", i), 32'(alloc_ready), 1);
            chk($sformatf("fill%0d_index", i), 32'(alloc_index), i);
        end
        @(negedge clk);
        drive_alloc(1, 9, 9, 9, 32'h999);
        #1;
        chk("full_ready", 32'(alloc_ready), 0);
        chk("full_index", 32'(alloc_index), 0);
        @(negedge clk);
        idle_in();
        complete_valid = 1'b1; complete_index = 3'd0;
        #1;
        chk("full_reject_index", 32'(alloc_index), 0);
        chk("full_reject_ready", 32'(alloc_ready), 0);
        @(negedge clk);
        idle_in();
        drive_alloc(0, 1, 2, 3, 32'h600);
        #1;
        chk("fullcommit_ready", 32'(alloc_ready), 0);
        chk("fullcommit_cv0", 32'(commit_valid), 0);
        @(negedge clk);
        #1;
        chk("fullcommit_cv", 32'(commit_valid), 1);
        chk("fullcommit_pc", commit_pc, 500);
        chk("fullcommit_fp", 32'(free_preg), 16);
        chk("fullcommit_ready2", 32'(alloc_ready), 1);
        chk("fullcommit_index", 32'(alloc_index), 0);
        @(negedge clk);
        idle_in();
        #1;
        chk("fullcommit_accepted", 32'(alloc_index), 1);
        chk("fullcommit_full_again", 32'(alloc_ready), 0);

        // Ten alloc/complete/commit rounds across the wrap point.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            idle_in();
            drive_alloc(1, i, i, i + 32, 32'(1000 + 4 * i));
            #1;
            chk($sformatf("wrap%0d_index", i), 32'(alloc_index), i % 8);
            @(negedge clk);
            idle_in();
            complete_valid = 1'b1; complete_index = 3'(i % 8);
            @(negedge clk);
            idle_in();
            @(negedge clk);
            #1;
            chk($sformatf("wrap%0d_cv", i), 32'(commit_valid), 1);
            chk($sformatf("wrap%0d_pc", i), commit_pc, 32'(1000 + 4 * i));
            chk($sformatf("wrap%0d_fp", i), 32'(free_preg), i + 32);
        end

        // Random traffic against the queue model.
        do_reset();
        q.delete();
        m_tail = 0; m_busy = 0;
        x_cv = 0; x_cpc = '0; x_fv = 0; x_fp = 0; x_rb = 0; x_rv = 0; x_ro = 0; x_rf = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            chk("rnd_cv", 32'(commit_valid), x_cv);
            chk("rnd_cpc", commit_pc, x_cpc);
            chk("rnd_fv", 32'(free_valid), x_fv);
            chk("rnd_fp", 32'(free_preg), x_fp);
            chk("rnd_rb", 32'(rollback_valid), x_rb);
            chk("rnd_rvreg", 32'(rollback_vreg), x_rv);
            chk("rnd_rold", 32'(rollback_old_preg), x_ro);
            chk("rnd_rfree", 32'(rollback_free_preg), x_rf);
            idle_in();
            if ($urandom_range(99) < ((c / 500) % 2 == 0 ? 75 : 35))
                drive_alloc(int'($urandom_range(1)), int'($urandom_range(31)), int'($urandom_range(63)),
                            int'($urandom_range(63)), $urandom);
            complete_valid = 1'($urandom_range(99) < ((c / 500) % 2 == 0 ? 30 : 70));
            complete_index = 3'($urandom_range(7));
            flush          = 1'($urandom_range(39) == 0);
            #1;
            chk("rnd_ready", 32'(alloc_ready), (!m_busy && q.size() != 8 && !flush) ? 1 : 0);
            chk("rnd_index", 32'(alloc_index), m_tail);
            chk("rnd_empty", 32'(empty), (q.size() == 0) ? 1 : 0);
            chk("rnd_busy", 32'(busy), m_busy ? 1 : 0);
            model_edge();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
